// File: rtl/hsi_accel_obi_master_if.sv
// Command handshake plus OBI request/response channel bundled for the accelerator master.
// Member names keep the block's port names so each wire traces straight to its role.
interface hsi_accel_obi_master_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [31:0] cmd_op_i;
    logic [31:0] cmd_bands_i;

    logic        req_o;
    logic        we_o;
    logic [3:0]  be_o;
    logic [31:0] addr_o;
    logic [31:0] wdata_o;

    logic        gnt_i;
    logic        rvalid_i;
    logic [31:0] rdata_i;
    logic        err_i;

    modport master (
        input  cmd_valid_i, cmd_op_i, cmd_bands_i, gnt_i, rvalid_i, rdata_i, err_i,
        output cmd_ready_o, req_o, we_o, be_o, addr_o, wdata_o
    );

    modport slave (
        output cmd_valid_i, cmd_op_i, cmd_bands_i, gnt_i, rvalid_i, rdata_i, err_i,
        input  cmd_ready_o, req_o, we_o, be_o, addr_o, wdata_o
    );
endinterface

// File: rtl/hsi_accel_obi_master.sv
// OBI master that programs OP/BANDS/START on the accelerator, then polls STATUS
// until idle, error, bus fault or poll timeout. One outstanding transaction at a time.
module hsi_accel_obi_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          POLL_MAX  = 255,
    parameter int          POLL_GAP  = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    hsi_accel_obi_master_if.master        bus,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [3:0]                    err_code_o,
    output logic                          bus_err_o,
    output logic                          timeout_o
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RSP,
        GAP,
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  step, step_nxt;
    logic [31:0] op_q, op_nxt;
    logic [31:0] bands_q, bands_nxt;
    logic [31:0] poll_cnt, poll_nxt;
    logic [31:0] gap_cnt, gap_nxt;
    logic [3:0]  err_code_nxt;
    logic        bus_err_nxt;
    logic        timeout_nxt;
    logic        stat_busy;
    logic [3:0]  stat_code;
    logic        unused_rdata;

    assign stat_busy    = bus.rdata_i[0];
    assign stat_code    = bus.rdata_i[4:1];
    assign unused_rdata = ^bus.rdata_i[31:5];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            step       <= 2'd0;
            op_q       <= 32'd0;
            bands_q    <= 32'd0;
            poll_cnt   <= 32'd0;
            gap_cnt    <= 32'd0;
            err_code_o <= 4'd0;
            bus_err_o  <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            state      <= state_nxt;
            step       <= step_nxt;
            op_q       <= op_nxt;
            bands_q    <= bands_nxt;
            poll_cnt   <= poll_nxt;
            gap_cnt    <= gap_nxt;
            err_code_o <= err_code_nxt;
            bus_err_o  <= bus_err_nxt;
            timeout_o  <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        step_nxt     = step;
        op_nxt       = op_q;
        bands_nxt    = bands_q;
        poll_nxt     = poll_cnt;
        gap_nxt      = gap_cnt;
        err_code_nxt = err_code_o;
        bus_err_nxt  = bus_err_o;
        timeout_nxt  = timeout_o;

        bus.cmd_ready_o = (state == IDLE) && !rst_i;
        bus.req_o       = 1'b0;
        bus.we_o        = 1'b0;
        bus.be_o        = 4'h0;
        bus.addr_o      = 32'd0;
        bus.wdata_o     = 32'd0;
        busy_o          = (state != IDLE);
        done_o          = (state == DONE);

        case (state)
            IDLE: begin
                if (bus.cmd_valid_i && bus.cmd_ready_o) begin
                    op_nxt       = bus.cmd_op_i;
                    bands_nxt    = bus.cmd_bands_i;
                    step_nxt     = 2'd0;
                    poll_nxt     = 32'd0;
                    gap_nxt      = 32'd0;
                    err_code_nxt = 4'd0;
                    bus_err_nxt  = 1'b0;
                    timeout_nxt  = 1'b0;
                    state_nxt    = REQ;
                end
            end
            REQ: begin
                // Step selects register: 0=OP, 1=BANDS, 2=START, 3=STATUS (read).
                bus.req_o  = 1'b1;
                bus.be_o   = 4'hF;
                bus.addr_o = BASE_ADDR + {28'd0, step, 2'b00};
                bus.we_o   = (step != 2'd3);
                case (step)
                    2'd0:    bus.wdata_o = op_q;
                    2'd1:    bus.wdata_o = bands_q;
                    2'd2:    bus.wdata_o = 32'd1;
                    default: bus.wdata_o = 32'd0;
                endcase
                if (bus.gnt_i) state_nxt = RSP;
            end
            RSP: begin
                if (bus.rvalid_i) begin
                    if (bus.err_i) begin
                        bus_err_nxt = 1'b1;
                        state_nxt   = DONE;
                    end else if (step != 2'd3) begin
                        step_nxt  = step + 2'd1;
                        state_nxt = REQ;
                    end else begin
                        poll_nxt     = poll_cnt + 32'd1;
                        err_code_nxt = stat_code;
                        if (!stat_busy || stat_code != 4'd0) begin
                            state_nxt = DONE;
                        end else if (poll_cnt + 32'd1 >= 32'(POLL_MAX)) begin
                            timeout_nxt = 1'b1;
                            state_nxt   = DONE;
                        end else if (POLL_GAP == 0) begin
                            state_nxt = REQ;
                        end else begin
                            gap_nxt   = 32'd0;
                            state_nxt = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt >= 32'(POLL_GAP - 1)) begin
                    gap_nxt   = 32'd0;
                    state_nxt = REQ;
                end else begin
                    gap_nxt = gap_cnt + 32'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hsi_accel_obi_master.sv
// Randomized bench: stimulus pushes expected bus transactions and final flags from a
// transaction-level model; a monitor pops and compares as the DUT grants and completes.
module tb_hsi_accel_obi_master;
    localparam logic [31:0] BASE = 32'h4000_0100;
    localparam int PMAX = 4;
    localparam int PGAP = 2;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        logic [3:0] code;
        logic       be;
        logic       to;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hsi_accel_obi_master_if ifc();
    logic       busy, done, bus_err, timeout;
    logic [3:0] err_code;

    hsi_accel_obi_master #(.BASE_ADDR(BASE), .POLL_MAX(PMAX), .POLL_GAP(PGAP)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (ifc.master),
        .busy_o     (busy),
        .done_o     (done),
        .err_code_o (err_code),
        .bus_err_o  (bus_err),
        .timeout_o  (timeout)
    );

    txn_t        exp_txn[$];
    res_t        exp_res[$];
    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] stat_q[$];
    int          err_idx   = -1;
    int          stall_cfg = 0;
    int          txn_idx   = 0;
    bit          zw        = 1'b1;

    logic        r_gnt = 1'b0, r_rv = 1'b0, r_err = 1'b0, spur = 1'b0;
    logic [31:0] r_rdata = 32'd0;
    assign ifc.gnt_i    = r_gnt;
    assign ifc.rvalid_i = r_rv | spur;
    assign ifc.err_i    = r_err;
    assign ifc.rdata_i  = r_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: register programming sequence followed by STATUS polling rules.
    task automatic model(input logic [31:0] op, input logic [31:0] bands,
                         input logic [31:0] st[$], input int eidx);
        res_t        r;
        logic [31:0] wd[3];
        logic [31:0] s;
        r  = '{code: 4'd0, be: 1'b0, to: 1'b0};
        wd = '{op, bands, 32'd1};
        for (int k = 0; k < 3; k++) begin
            exp_txn.push_back('{addr: 32'(BASE + 32'(4 * k)), we: 1'b1, data: wd[k]});
            if (eidx == k) begin
                r.be = 1'b1;
                exp_res.push_back(r);
                return;
            end
        end
        for (int rd = 1; rd <= PMAX; rd++) begin
            exp_txn.push_back('{addr: 32'(BASE + 32'hC), we: 1'b0, data: 32'd0});
            if (eidx == 2 + rd) begin
                r.be = 1'b1;
                break;
            end
            s = (rd - 1 < st.size()) ? st[rd-1] : 32'h1;
            r.code = s[4:1];
            if (!s[0] || r.code != 4'd0) break;
            if (rd == PMAX) r.to = 1'b1;
        end
        exp_res.push_back(r);
    endtask

    // Responder: optional grant stall, then read/write response after 0..2 cycles.
    initial begin
        bit in_req = 1'b0, pend = 1'b0, cur_we = 1'b0;
        int stall_left = 0, rdly = 0;
        forever begin
            @(negedge clk);
            r_gnt = 1'b0; r_rv = 1'b0; r_err = 1'b0; r_rdata = $urandom;
            if (rst) begin
                in_req = 1'b0; pend = 1'b0;
            end else if (pend) begin
                if (rdly > 0) rdly--;
                else begin
                    r_rv  = 1'b1;
                    r_err = (txn_idx == err_idx);
                    if (!cur_we) r_rdata = (stat_q.size() > 0) ? stat_q.pop_front() : 32'h1;
                    pend = 1'b0;
                    txn_idx++;
                end
            end else if (ifc.req_o) begin
                if (!in_req) begin in_req = 1'b1; stall_left = stall_cfg; end
                if (stall_left > 0) stall_left--;
                else begin
                    r_gnt = 1'b1; in_req = 1'b0; pend = 1'b1; cur_we = ifc.we_o;
                    rdly = zw ? 0 : $urandom_range(0, 2);
                end
            end else begin
                in_req = 1'b0;
            end
        end
    end

    // Monitor
    initial begin
        bit          prev_busy = 1'b0, prev_req = 1'b0, prev_done = 1'b0, last_read = 1'b0;
        logic [31:0] prev_addr = 32'd0, prev_wdata = 32'd0;
        int          idle = 0;
        txn_t        t;
        res_t        r;
        forever begin
            @(negedge clk); #1;
            if (!rst) begin
                if (busy) chk("ready_while_busy", ifc.cmd_ready_o, 0);
                if (busy && !prev_busy) begin
                    chk("clr_err_code", err_code, 0);
                    chk("clr_bus_err", bus_err, 0);
                    chk("clr_timeout", timeout, 0);
                    last_read = 1'b0;
                end
                if (ifc.req_o) begin
                    chk("be", ifc.be_o, 32'hF);
                    if (prev_req) begin
                        chk("addr_stable", ifc.addr_o, prev_addr);
                        chk("wdata_stable", ifc.wdata_o, prev_wdata);
                    end else if (last_read && !ifc.we_o) begin
                        chk("poll_gap", idle >= PGAP + 1, 1);
                    end
                    if (r_gnt) begin
                        if (exp_txn.size() == 0) chk("unexpected_txn", ifc.addr_o, 32'hFFFF_FFFF);
                        else begin
                            t = exp_txn.pop_front();
                            chk("txn_addr", ifc.addr_o, t.addr);
                            chk("txn_we", ifc.we_o, t.we);
                            if (t.we) chk("txn_wdata", ifc.wdata_o, t.data);
                        end
                        last_read = !ifc.we_o;
                        idle = 0;
                    end
                end else if (busy) begin
                    idle++;
                end
                if (done) begin
                    chk("done_pulse", prev_done, 0);
                    chk("missing_txn", exp_txn.size(), 0);
                    if (exp_res.size() == 0) chk("unexpected_done", 1, 0);
                    else begin
                        r = exp_res.pop_front();
                        chk("err_code", err_code, r.code);
                        chk("bus_err", bus_err, r.be);
                        chk("timeout", timeout, r.to);
                    end
                end
            end
            prev_busy  = busy;
            prev_done  = done;
            prev_req   = ifc.req_o && !r_gnt;
            prev_addr  = ifc.addr_o;
            prev_wdata = ifc.wdata_o;
        end
    end

    task automatic run_cmd(input logic [31:0] op, input logic [31:0] bands,
                           input logic [31:0] st[$], input int eidx, input int stall,
                           input bit zero, output int lat);
        int n;
        n = 0;
        while (!ifc.cmd_ready_o && n < 100) begin @(negedge clk); n++; end
        chk("cmd_ready", ifc.cmd_ready_o, 1);
        stat_q = st; err_idx = eidx; stall_cfg = stall; zw = zero; txn_idx = 0;
        model(op, bands, st, eidx);
        ifc.cmd_valid_i = 1'b1; ifc.cmd_op_i = op; ifc.cmd_bands_i = bands;
        @(negedge clk);
        n = 1;
        while (!done && n < 3000) begin
            // Junk commands while busy must be dropped, not queued.
            ifc.cmd_valid_i = (n < 5) && ($urandom_range(0, 1) == 1);
            ifc.cmd_op_i    = $urandom;
            ifc.cmd_bands_i = $urandom;
            @(negedge clk);
            n++;
        end
        ifc.cmd_valid_i = 1'b0;
        chk("done_seen", done, 1);
        lat = n;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] st[$];
        int          nb, eidx;
        logic [3:0]  code;
        logic [31:0] w;
        ifc.cmd_valid_i = 1'b0; ifc.cmd_op_i = 32'd0; ifc.cmd_bands_i = 32'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", ifc.cmd_ready_o, 0);
        chk("rst_req", ifc.req_o, 0);
        chk("rst_we", ifc.we_o, 0);
        chk("rst_be", ifc.be_o, 0);
        chk("rst_addr", ifc.addr_o, 0);
        chk("rst_wdata", ifc.wdata_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", ifc.cmd_ready_o, 1);

        st = '{32'h0};
        run_cmd(32'd1, 32'd3, st, -1, 0, 1'b1, lat);
        chk("lat_cross", lat, 9);
        st = '{32'h2};
        run_cmd(32'd1, 32'd2, st, -1, 0, 1'b1, lat);
        st = '{32'h8};
        run_cmd(32'd2, 32'd4, st, -1, 3, 1'b1, lat);
        st = '{32'h1, 32'h1, 32'h1, 32'h0};
        run_cmd(32'd2, 32'd5, st, -1, 0, 1'b1, lat);
        st = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h1};
        run_cmd(32'd1, 32'd6, st, -1, 0, 1'b1, lat);
        st = '{32'h0};
        run_cmd(32'd1, 32'd7, st, 1, 0, 1'b1, lat);
        run_cmd(32'd2, 32'd8, st, -1, 1, 1'b0, lat);

        // Reset while a request is stalled, then a stray response.
        stat_q = '{32'h0}; err_idx = -1; stall_cfg = 20; zw = 1'b1; txn_idx = 0;
        ifc.cmd_valid_i = 1'b1; ifc.cmd_op_i = 32'd1; ifc.cmd_bands_i = 32'd3;
        @(negedge clk);
        ifc.cmd_valid_i = 1'b0;
        @(negedge clk);
        chk("req_before_rst", ifc.req_o, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_req", ifc.req_o, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", ifc.cmd_ready_o, 0);
        rst = 1'b0; spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("late_rvalid_busy", busy, 0);
        chk("late_rvalid_req", ifc.req_o, 0);
        chk("late_rvalid_ready", ifc.cmd_ready_o, 1);
        @(negedge clk);
        chk("late_rvalid_idle", busy, 0);
        exp_txn.delete();
        exp_res.delete();

        for (int i = 0; i < 40; i++) begin
            st.delete();
            nb = $urandom_range(0, 5);
            for (int j = 0; j < nb; j++) st.push_back(($urandom & 32'hFFFF_FFE0) | 32'h1);
            code = 4'($urandom_range(0, 15));
            w = ($urandom & 32'hFFFF_FFE0) | {27'd0, code, 1'b0};
            if (code != 4'd0 && $urandom_range(0, 1) == 1) w = w | 32'h1;
            st.push_back(w);
            while (st.size() < PMAX + 1) st.push_back(32'h1);
            eidx = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : -1;
            run_cmd($urandom, $urandom, st, eidx, $urandom_range(0, 2),
                    bit'($urandom_range(0, 1)), lat);
        end

        repeat (4) @(negedge clk);
        chk("leftover_results", exp_res.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
